// File: rtl/cla_seq_pkg.sv
// Shared definitions for sequencers built around the 16-bit carry-lookahead adder.
// Contents:
//   SLICE_W          width of one adder slice (16 bits)
//   ST_IDLE/RUN/DONE state encodings shared by CLA-based sequencers
//   state_t          FSM state type using those encodings
//   idx_width()      width of a slice index for a given slice count (at least 1)
package cla_seq_pkg;

  localparam int SLICE_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // A single-slice sequencer still needs a 1-bit index register.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/bit_16_carry_lookahead.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups with a
// group-level lookahead carry chain.
// Ports:
//   a, b  16-bit addends
//   c_0   carry in
//   s     16-bit sum
//   c_16  carry out of bit 15
module bit_16_carry_lookahead (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_0,
  output logic [15:0] s,
  output logic        c_16
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    c  = '0;
    gg = '0;
    gp = '0;
    c[0] = c_0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k]) |
                 (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      // Group carry comes from group generate/propagate, not the inner chain.
      c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
    end
    s    = p ^ c[15:0];
    c_16 = c[16];
  end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Multi-word add/subtract sequencer. A WORDS*16-bit add or subtract is run
// through one shared 16-bit CLA, one slice per cycle, least significant slice
// first, with the inter-slice carry held in a register.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   operand handshake; op_sub selects a-b (a + ~b + 1)
//   a, b                WORDS*16-bit operands
//   out_valid/out_ready result handshake
//   sum                 WORDS*16-bit result
//   carry_out           final carry (for subtract, 1 = no borrow)
//   overflow            two's-complement overflow of the full-width operation
//   dbg_state           current FSM state (ST_IDLE / ST_RUN / ST_DONE)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// 1. in_ready is 1 only in IDLE; out_valid is 1 only in DONE. The producer holds
// operands until accepted; sum/carry_out/overflow stay stable while out_valid=1
// and out_ready=0, for any number of cycles.
module multiword_add_sequencer
  import cla_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op_sub,
  input  logic [WORDS*16-1:0]    a,
  input  logic [WORDS*16-1:0]    b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORDS*16-1:0]    sum,
  output logic                   carry_out,
  output logic                   overflow,
  output logic [1:0]             dbg_state
);

  localparam int W     = WORDS * SLICE_W;
  localparam int IDX_W = idx_width(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t state;
  state_t state_next;

  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;     // already inverted for subtract
  logic [W-1:0]       sum_q;
  logic               carry_q;
  logic               carry_out_q;
  logic               overflow_q;
  logic [IDX_W-1:0]   idx;

  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W-1:0] s_sl;
  logic               c16;
  logic               accept;
  logic               last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (idx == LAST_IDX);
  assign dbg_state = state;

  assign a_sl = a_q[int'(idx)*SLICE_W +: SLICE_W];
  assign b_sl = b_q[int'(idx)*SLICE_W +: SLICE_W];

  bit_16_carry_lookahead u_cla (
    .a    (a_sl),
    .b    (b_sl),
    .c_0  (carry_q),
    .s    (s_sl),
    .c_16 (c16)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      idx         <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= op_sub ? ~b : b;
      // Subtract's "+1" enters as the carry into the least significant slice.
      carry_q <= op_sub;
      idx     <= '0;
    end else if (state == RUN) begin
      sum_q[int'(idx)*SLICE_W +: SLICE_W] <= s_sl;
      carry_q <= c16;
      if (last) begin
        carry_out_q <= c16;
        // On the top slice the slice msbs are the operand msbs; b_q is the
        // possibly inverted operand, so this also covers subtract.
        overflow_q  <= (a_sl[SLICE_W-1] == b_sl[SLICE_W-1]) &&
                       (s_sl[SLICE_W-1] != a_sl[SLICE_W-1]);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule
